// File: rtl/alu_seq_if.sv
// Request/response bundle between an ALU_SEQ requester and the alu_seq core.
// The requester drives the operation and operands; the core returns status and results.
interface alu_seq_if #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 8
);
    logic             start;
    logic [3:0]       opcode;
    logic             opcode_mode;
    logic [IMM_W-1:0] immediate;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rA;
    logic [WIDTH-1:0] rB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             write_rD;
    logic             write_pc;
    logic [1:0]       memory_mode;
    logic             flag_z;
    logic             flag_c;

    modport master (
        output start, opcode, opcode_mode, immediate, pc, rA, rB,
        input  busy, done, out, write_rD, write_pc, memory_mode, flag_z, flag_c
    );

    modport slave (
        input  start, opcode, opcode_mode, immediate, pc, rA, rB,
        output busy, done, out, write_rD, write_pc, memory_mode, flag_z, flag_c
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle EXEC for ALU/branch/memory ops, WIDTH-cycle shift-add MUL.
// Operands are latched on an accepted start, so the bus may change while busy.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 8
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_OR     = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_NOT    = 4'd5;
    localparam logic [3:0] OP_SHIFTL = 4'd6;
    localparam logic [3:0] OP_SHIFTR = 4'd7;
    localparam logic [3:0] OP_LOAD   = 4'd8;
    localparam logic [3:0] OP_CMP    = 4'd9;
    localparam logic [3:0] OP_JMP    = 4'd10;
    localparam logic [3:0] OP_JMPC   = 4'd11;
    localparam logic [3:0] OP_READ   = 4'd12;
    localparam logic [3:0] OP_WRITE  = 4'd13;
    localparam logic [3:0] OP_MUL    = 4'd14;

    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    localparam logic [1:0] CMP_EQ    = 2'd0;
    localparam logic [1:0] CMP_RA_GT = 2'd1;
    localparam logic [1:0] CMP_RB_GT = 2'd2;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             wr_rd;
        logic             wr_pc;
        logic [1:0]       mem;
    } exec_t;

    state_t                    state;
    logic [3:0]                op_r;
    logic                      mode_r;
    logic [IMM_W-1:0]          imm_r;
    logic [WIDTH-1:0]          pc_r;
    logic [WIDTH-1:0]          ra_r;
    logic [WIDTH-1:0]          rb_r;
    logic signed [2*WIDTH-1:0] acc;
    logic signed [2*WIDTH-1:0] mcand;
    logic signed [2*WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0]          mplier;
    logic [SH_W-1:0]           cnt;
    logic                      mul_last;
    logic                      mul_ovf;
    exec_t                     ex;

    logic             done_reg;
    logic [WIDTH-1:0] out_reg;
    logic             wr_rd_reg;
    logic             wr_pc_reg;
    logic [1:0]       mem_reg;
    logic             z_reg;
    logic             c_reg;

    function automatic exec_t exec_op(
        input logic [3:0]       op,
        input logic             mode,
        input logic [IMM_W-1:0] imm,
        input logic [WIDTH-1:0] pc,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        exec_t              r;
        logic [WIDTH:0]     wide;
        logic signed [WIDTH:0] swide;
        logic [WIDTH-1:0]   imm_ext;
        logic [SH_W-1:0]    amt;
        logic               lt;
        logic               gt;
        r       = '0;
        r.valid = 1'b1;
        r.wr_rd = 1'b1;
        r.mem   = MEM_NOP;
        wide    = '0;
        swide   = '0;
        amt     = b[SH_W-1:0];
        imm_ext = mode ? {{(WIDTH-IMM_W){1'b0}}, imm} : {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
        lt      = mode ? (a < b) : ($signed(a) < $signed(b));
        gt      = mode ? (a > b) : ($signed(a) > $signed(b));
        case (op)
            OP_ADD: begin
                wide    = {1'b0, a} + {1'b0, b};
                r.res   = wide[WIDTH-1:0];
                r.carry = wide[WIDTH];
            end
            OP_SUB: begin
                wide    = {1'b0, a} - {1'b0, b};
                r.res   = wide[WIDTH-1:0];
                r.carry = wide[WIDTH];
            end
            OP_OR:  r.res = a | b;
            OP_AND: r.res = a & b;
            OP_XOR: r.res = a ^ b;
            OP_NOT: r.res = ~a;
            OP_SHIFTL: begin
                // Extra MSB catches the last bit shifted out; stays 0 for amount 0.
                wide    = {1'b0, a} << amt;
                r.res   = wide[WIDTH-1:0];
                r.carry = wide[WIDTH];
            end
            OP_SHIFTR: begin
                if (mode) begin
                    wide = {a, 1'b0} >> amt;
                end else begin
                    swide = $signed({a, 1'b0}) >>> amt;
                    wide  = swide;
                end
                r.res   = wide[WIDTH:1];
                r.carry = wide[0];
            end
            OP_LOAD: r.res = mode ? {{(WIDTH-IMM_W){1'b0}}, imm} : {imm, {(WIDTH-IMM_W){1'b0}}};
            OP_CMP:  r.res = {{(WIDTH-2){1'b0}}, lt ? CMP_RB_GT : (gt ? CMP_RA_GT : CMP_EQ)};
            OP_JMP, OP_JMPC: begin
                r.res   = pc + imm_ext;
                r.wr_rd = 1'b0;
                r.wr_pc = (op == OP_JMP) ? 1'b1 : (a == b);
            end
            OP_READ: begin
                r.res = a;
                r.mem = MEM_READ;
            end
            OP_WRITE: begin
                r.res   = a;
                r.wr_rd = 1'b0;
                r.mem   = MEM_WRITE;
            end
            default: begin
                r.valid = 1'b0;
                r.wr_rd = 1'b0;
            end
        endcase
        return r;
    endfunction

    always_comb ex = exec_op(op_r, mode_r, imm_r, pc_r, ra_r, rb_r);

    // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode, so the last step subtracts.
    always_comb begin
        mul_last = (cnt == SH_W'(WIDTH - 1));
        mul_sum  = acc;
        if (mplier[0]) begin
            mul_sum = (!mode_r && mul_last) ? (acc - mcand) : (acc + mcand);
        end
        mul_ovf = mode_r ? (|mul_sum[2*WIDTH-1:WIDTH])
                         : (mul_sum[2*WIDTH-1:WIDTH] != {WIDTH{mul_sum[WIDTH-1]}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            done_reg  <= 1'b0;
            out_reg   <= '0;
            wr_rd_reg <= 1'b0;
            wr_pc_reg <= 1'b0;
            mem_reg   <= MEM_NOP;
            z_reg     <= 1'b0;
            c_reg     <= 1'b0;
            op_r      <= '0;
            mode_r    <= 1'b0;
            imm_r     <= '0;
            pc_r      <= '0;
            ra_r      <= '0;
            rb_r      <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_r   <= bus.opcode;
                        mode_r <= bus.opcode_mode;
                        imm_r  <= bus.immediate;
                        pc_r   <= bus.pc;
                        ra_r   <= bus.rA;
                        rb_r   <= bus.rB;
                        acc    <= '0;
                        mcand  <= bus.opcode_mode ? {{WIDTH{1'b0}}, bus.rA}
                                                  : {{WIDTH{bus.rA[WIDTH-1]}}, bus.rA};
                        mplier <= bus.rB;
                        cnt    <= '0;
                        state  <= (bus.opcode == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    done_reg <= 1'b1;
                    state    <= IDLE;
                    if (ex.valid) begin
                        out_reg   <= ex.res;
                        z_reg     <= (ex.res == '0);
                        c_reg     <= ex.carry;
                        wr_rd_reg <= ex.wr_rd;
                        wr_pc_reg <= ex.wr_pc;
                        mem_reg   <= ex.mem;
                    end else begin
                        wr_rd_reg <= 1'b0;
                        wr_pc_reg <= 1'b0;
                        mem_reg   <= MEM_NOP;
                    end
                end
                MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (mul_last) begin
                        done_reg  <= 1'b1;
                        state     <= IDLE;
                        out_reg   <= mul_sum[WIDTH-1:0];
                        z_reg     <= (mul_sum[WIDTH-1:0] == '0);
                        c_reg     <= mul_ovf;
                        wr_rd_reg <= 1'b1;
                        wr_pc_reg <= 1'b0;
                        mem_reg   <= MEM_NOP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_reg;
    assign bus.out         = out_reg;
    assign bus.write_rD    = wr_rd_reg;
    assign bus.write_pc    = wr_pc_reg;
    assign bus.memory_mode = mem_reg;
    assign bus.flag_z      = z_reg;
    assign bus.flag_c      = c_reg;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: datapath width; legal values 8..64, power of two.
REQ-002 Parameter IMM_W, default 8: immediate width; SHALL be less than WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 opcode  input  4  operation; encodings per ops.vh, plus new code MUL.
REQ-007 opcode_mode  input  1  0=signed/HI/arith, 1=unsigned/LO/logical, per opcode.
REQ-008 immediate  input  IMM_W  immediate operand.
REQ-009 pc, rA, rB  input  WIDTH each  operands.
REQ-010 busy  output  1  high while an operation is in flight.
REQ-011 done  output  1  one-cycle pulse; result outputs valid from that cycle.
REQ-012 out  output  WIDTH  result / target address / memory address.
REQ-013 write_rD, write_pc  output  1 each  writeback enables.
REQ-014 memory_mode  output  2  MEM_NOP/MEM_READ/MEM_WRITE per mem_acc.vh.
REQ-015 flag_z, flag_c  output  1 each  zero and carry/borrow of last result.

Function
REQ-016 States SHALL be IDLE, EXEC, MUL; inputs captured into internal registers on accepted start.
REQ-017 IDLE + start: non-MUL opcode -> EXEC; MUL -> MUL; busy rises next cycle.
REQ-018 EXEC lasts one cycle: outputs updated, done=1, return to IDLE; start-to-done latency 2 cycles.
REQ-019 MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, then done=1 and IDLE; out = low WIDTH bits of product; flag_c=1 if high half nonzero (unsigned) or not a sign-extension of low half (signed).
REQ-020 start while busy SHALL be ignored; operands changing while busy SHALL not affect the result.
REQ-021 done and busy SHALL never be high in the same cycle; back-to-back start in the done cycle accepted (IDLE reached that cycle).
REQ-022 out, write_rD, write_pc, memory_mode, flags hold last values between done pulses.
REQ-023 ADD/SUB: WIDTH-bit wraparound; flag_c = carry-out (ADD) or borrow (SUB); flag_z = (out==0).
REQ-024 OR/AND/XOR/NOT: bitwise; flag_c=0.
REQ-025 SHIFTL/SHIFTR: shift amount rB[log2(WIDTH)-1:0]; SHIFTR arithmetic when opcode_mode=0, logical when 1; flag_c = last bit shifted out, 0 for amount 0.
REQ-026 LOAD: HI places immediate in top IMM_W bits, rest 0; LO zero-extends into low bits.
REQ-027 CMP: rA<rB -> CMP_RB_GT, rA>rB -> CMP_RA_GT, else CMP_EQ (cmp_res.vh), signed or unsigned per mode, zero-extended to WIDTH.
REQ-028 JMP: out = pc + immediate, sign-extended (mode 0) or zero-extended (mode 1), wraparound; write_pc=1. JMPC identical, write_pc = (rA==rB).
REQ-029 READ: out=rA, write_rD=1, MEM_READ; WRITE: out=rA, write_rD=0, MEM_WRITE; all others MEM_NOP.
REQ-030 write_rD=1 for ALU/LOAD/CMP/MUL/READ, 0 for WRITE/JMP/JMPC; write_pc=0 except jumps.
REQ-031 Undefined opcode: done pulses, write_rD=write_pc=0, MEM_NOP, out unchanged.

Reset
REQ-032 reset SHALL asynchronously force IDLE, busy=0, done=0, out=0, write_rD=0, write_pc=0, memory_mode=MEM_NOP, flags=0.
REQ-033 reset during MUL SHALL abort it with no done pulse; first start after reset release accepted normally.

Verification
REQ-034 WIDTH=16, ADD unsigned 0xFFFF+0x0001 -> done 2 cycles after start, out=0x0000, flag_z=1, flag_c=1, write_rD=1.
REQ-035 CMP signed rA=0xFFFF, rB=0x0001 -> out=CMP_RB_GT; unsigned same operands -> CMP_RA_GT.
REQ-036 MUL signed rA=0xFFFD(-3), rB=0x0007 -> busy 16 cycles, out=0xFFEB, flag_c=0; start pulses during busy ignored.
REQ-037 JMP signed pc=0x0010, immediate=0xFE -> out=0x000E, write_pc=1; JMPC with rA!=rB -> write_pc=0.
REQ-038 SHIFTR mode 0 rA=0x8001, rB=4 -> out=0xF800, flag_c=0; mode 1 -> out=0x0800.
REQ-039 reset asserted mid-MUL, cycle 5 -> outputs at reset values immediately, no done; WIDTH=32 rerun of REQ-034 with 0xFFFFFFFF+1 -> out=0, flag_c=1.
